// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and FSM state types for the slave RAM.
//   burst_e   : AxBURST encodings (FIXED/INCR/WRAP, 2'b11 reserved)
//   resp_e    : xRESP encodings
//   w_state_e : write-path FSM states
//   r_state_e : read-path FSM states
package axi4_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10,
    BurstRsvd  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/axi4_if.sv
// AXI4 bus bundle. master_mp drives requests and write data; slave_mp drives
// ready signals and the B/R response channels. Sideband fields (lock, cache,
// prot, qos, region, user, wid) are carried but not interpreted by the RAM.
interface axi4_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 8,
  parameter int unsigned USER_W = 1
) ();
  // Write address
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic [3:0]          awregion;
  logic [USER_W-1:0]   awuser;
  logic                awvalid;
  logic                awready;
  // Write data
  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic [USER_W-1:0]   wuser;
  logic                wvalid;
  logic                wready;
  // Write response
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  // Read address
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic [3:0]          arregion;
  logic [USER_W-1:0]   aruser;
  logic                arvalid;
  logic                arready;
  // Read data
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master_mp (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
           awuser, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
           aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave_mp (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
           awuser, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
           aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi4_burst_addr.sv
// Combinational AXI4 next-beat address generator.
//   addr_i      : current beat address
//   len_i       : burst length minus one
//   size_i      : log2 of bytes per beat
//   burst_i     : burst type (FIXED/INCR/WRAP; reserved treated as INCR)
//   next_addr_o : address of the following beat
module axi4_burst_addr
  import axi4_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        len_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_W'(1) << size_i;
    incr      = addr_i + step;
    // Wrap block is (len+1)*2**size bytes; legal WRAP lengths make this a power of 2.
    wrap_mask = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
    case (burst_i)
      BurstFixed: next_addr_o = addr_i;
      BurstWrap:  next_addr_o = (addr_i & ~wrap_mask) | (incr & wrap_mask);
      default:    next_addr_o = incr;
    endcase
  end

endmodule

// File: rtl/axi4_slave_ram.sv
// AXI4 slave backed by a simple dual-port RAM (byte-enabled write port,
// registered read port). Independent write and read FSMs, one outstanding
// transaction each.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   s_axi : AXI4 responder port (axi4_if.slave_mp)
module axi4_slave_ram
  import axi4_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 8,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic     clk,
  input  logic     rst,
  axi4_if.slave_mp s_axi
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0] MemBytes = (ADDR_W + 1)'(MEM_DEPTH * StrbW);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // ---------------------------------------------------------------- write path
  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   aw_id_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [7:0]        aw_len_q;
  logic [2:0]        aw_size_q;
  logic [1:0]        aw_burst_q;
  logic [7:0]        w_cnt_q;
  logic              w_err_q;
  logic [1:0]        bresp_q;
  logic [ADDR_W-1:0] w_next_addr;
  logic              aw_ready, w_ready, b_valid;
  logic              aw_hs, w_hs, w_last_beat, w_oob, w_size_bad, w_beat_err, mem_we;
  logic [IdxW-1:0]   w_idx;

  assign aw_hs       = s_axi.awvalid & aw_ready;
  assign w_hs        = s_axi.wvalid & w_ready;
  assign w_last_beat = (w_cnt_q == aw_len_q);
  assign w_oob       = ({1'b0, aw_addr_q} >= MemBytes);
  assign w_size_bad  = (aw_size_q > 3'(OffW));
  // A wlast that disagrees with the beat count, early or missing, poisons the burst.
  assign w_beat_err  = w_oob | (s_axi.wlast != w_last_beat);
  assign mem_we      = w_hs & ~w_oob & ~w_size_bad;
  assign w_idx       = aw_addr_q[OffW+IdxW-1:OffW];

  always_ff @(posedge clk) begin
    if (rst) w_state_q <= W_IDLE;
    else     w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_d = W_RESP;
      W_RESP:  if (s_axi.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    case (w_state_q)
      W_IDLE:  aw_ready = 1'b1;
      W_DATA:  w_ready  = 1'b1;
      W_RESP:  b_valid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
      bresp_q    <= RespOkay;
    end else if (aw_hs) begin
      aw_id_q    <= s_axi.awid;
      aw_addr_q  <= s_axi.awaddr;
      aw_len_q   <= s_axi.awlen;
      aw_size_q  <= s_axi.awsize;
      aw_burst_q <= s_axi.awburst;
      w_cnt_q    <= '0;
      w_err_q    <= (s_axi.awsize > 3'(OffW)) | (s_axi.awburst == BurstRsvd);
    end else if (w_hs) begin
      aw_addr_q <= w_next_addr;
      w_cnt_q   <= w_cnt_q + 8'd1;
      w_err_q   <= w_err_q | w_beat_err;
      if (w_last_beat) bresp_q <= (w_err_q | w_beat_err) ? RespSlverr : RespOkay;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < StrbW; b++) begin
        if (s_axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  axi4_burst_addr #(
    .ADDR_W (ADDR_W)
  ) u_w_addr (
    .addr_i      (aw_addr_q),
    .len_i       (aw_len_q),
    .size_i      (aw_size_q),
    .burst_i     (aw_burst_q),
    .next_addr_o (w_next_addr)
  );

  assign s_axi.awready = aw_ready;
  assign s_axi.wready  = w_ready;
  assign s_axi.bvalid  = b_valid;
  assign s_axi.bid     = aw_id_q;
  assign s_axi.bresp   = bresp_q;

  // ----------------------------------------------------------------- read path
  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   ar_id_q;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [7:0]        ar_len_q;
  logic [2:0]        ar_size_q;
  logic [1:0]        ar_burst_q;
  logic [7:0]        r_cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              rlast_q;
  logic [ADDR_W-1:0] r_next_addr;
  logic              ar_ready, r_valid, r_fetch;
  logic              ar_hs, r_hs, r_oob, r_size_bad;
  logic [IdxW-1:0]   r_idx;

  assign ar_hs      = s_axi.arvalid & ar_ready;
  assign r_hs       = r_valid & s_axi.rready;
  assign r_oob      = ({1'b0, ar_addr_q} >= MemBytes);
  assign r_size_bad = (ar_size_q > 3'(OffW));
  assign r_idx      = ar_addr_q[OffW+IdxW-1:OffW];

  always_ff @(posedge clk) begin
    if (rst) r_state_q <= R_IDLE;
    else     r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_FETCH;
      R_FETCH: r_state_d = R_DATA;
      R_DATA:  if (s_axi.rready) r_state_d = rlast_q ? R_IDLE : R_FETCH;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    ar_ready = 1'b0;
    r_fetch  = 1'b0;
    r_valid  = 1'b0;
    case (r_state_q)
      R_IDLE:  ar_ready = 1'b1;
      R_FETCH: r_fetch  = 1'b1;
      R_DATA:  r_valid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
    end else if (ar_hs) begin
      ar_id_q    <= s_axi.arid;
      ar_addr_q  <= s_axi.araddr;
      ar_len_q   <= s_axi.arlen;
      ar_size_q  <= s_axi.arsize;
      ar_burst_q <= s_axi.arburst;
      r_cnt_q    <= '0;
    end else if (r_hs) begin
      ar_addr_q <= r_next_addr;
      r_cnt_q   <= r_cnt_q + 8'd1;
    end
  end

  // Registered RAM read; a same-cycle write to this word is not yet visible,
  // so the read sees the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      rresp_q <= RespOkay;
      rlast_q <= 1'b0;
    end else if (r_fetch) begin
      rdata_q <= (r_oob | r_size_bad) ? '0 : mem[r_idx];
      rresp_q <= (r_oob | r_size_bad | (ar_burst_q == BurstRsvd)) ? RespSlverr : RespOkay;
      rlast_q <= (r_cnt_q == ar_len_q);
    end else if (r_hs && rlast_q) begin
      rlast_q <= 1'b0;
    end
  end

  axi4_burst_addr #(
    .ADDR_W (ADDR_W)
  ) u_r_addr (
    .addr_i      (ar_addr_q),
    .len_i       (ar_len_q),
    .size_i      (ar_size_q),
    .burst_i     (ar_burst_q),
    .next_addr_o (r_next_addr)
  );

  assign s_axi.arready = ar_ready;
  assign s_axi.rvalid  = r_valid;
  assign s_axi.rid     = ar_id_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rlast   = rlast_q;

  // Sideband fields carried by the bus but not interpreted here.
  logic unused_sideband;
  assign unused_sideband = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                             s_axi.awregion, s_axi.awuser, s_axi.wid, s_axi.wuser,
                             s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos,
                             s_axi.arregion, s_axi.aruser};

endmodule
